// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the memory stage
package mem_stage_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam int DEFAULT_LATENCY = 2;
  function automatic int cnt_width(input int lat);
    return (lat > 4) ? $clog2(lat) : 2;
  endfunction
endpackage

// File: rtl/data_ram.sv
// data_ram: byte-addressed big-endian RAM with combinational read and wraparound word access
module data_ram import mem_stage_pkg::*; #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  size,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] a1, a2, a3;
  // byte lane addresses wrap naturally at the address width
  always_comb begin
    a1 = addr + ADDR_WIDTH'(1);
    a2 = addr + ADDR_WIDTH'(2);
    a3 = addr + ADDR_WIDTH'(3);
    rdata = (size == SIZE_WORD) ? {mem[addr], mem[a1], mem[a2], mem[a3]} : {24'b0, mem[addr]};
  end
  // most significant byte lands at the lowest address
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= (size == SIZE_WORD) ? wdata[31:24] : wdata[7:0];
      if (size == SIZE_WORD) begin
        mem[a1] <= wdata[23:16];
        mem[a2] <= wdata[15:8];
        mem[a3] <= wdata[7:0];
      end
    end
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: fixed-latency data memory access with upstream stall and MEM/WB register
module mem_stage import mem_stage_pkg::*; #(
  parameter int ADDR_WIDTH     = 8,
  parameter int ACCESS_LATENCY = DEFAULT_LATENCY
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_load_store_instr,
  input  logic        MEM_load_instr,
  input  logic        MEM_size,
  input  logic        MEM_RF_enable,
  input  logic [31:0] MEM_address,
  input  logic [31:0] MEM_alu_result,
  input  logic [31:0] MEM_store_data,
  input  logic [3:0]  MEM_rd,
  output logic        MEM_stall,
  output logic        WB_RF_enable,
  output logic [3:0]  WB_rd,
  output logic [31:0] WB_data
);
  localparam int CNT_W = cnt_width(ACCESS_LATENCY);
  localparam bit MULTI = ACCESS_LATENCY > 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULTI ? ACCESS_LATENCY - 2 : 0);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic commit, ram_we;
  logic [31:0] rdata, result;
  data_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .size  (MEM_size),
    .addr  (MEM_address[ADDR_WIDTH-1:0]),
    .wdata (MEM_store_data),
    .rdata (rdata)
  );
  // access commits on the last cycle of its latency window; stall covers the cycles before it
  always_comb begin
    commit = MEM_load_store_instr && ((state == WAIT) ? (cnt == '0) : !MULTI);
    MEM_stall = !Reset && ((state == WAIT) ? (cnt != '0) : (MEM_load_store_instr && MULTI));
    ram_we = !Reset && commit && !MEM_load_instr;
    result = (MEM_load_store_instr && MEM_load_instr) ? rdata : MEM_alu_result;
  end
  // latency sequencer: IDLE launches an access, WAIT counts down to its commit
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (MEM_load_store_instr && MULTI) begin
        state <= WAIT;
        cnt   <= CNT_INIT;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      state <= IDLE;
    end
  end
  // MEM/WB register takes a bubble while stalled, otherwise the completed instruction
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      WB_RF_enable <= 1'b0;
      WB_rd        <= '0;
      WB_data      <= '0;
    end else if (MEM_stall) begin
      WB_RF_enable <= 1'b0;
      WB_rd        <= '0;
      WB_data      <= '0;
    end else begin
      WB_RF_enable <= MEM_RF_enable;
      WB_rd        <= MEM_rd;
      WB_data      <= result;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage against a byte-array memory model
module tb_mem_stage;
  import mem_stage_pkg::*;
  localparam int LAT = 2;
  logic Clk = 1'b0, Reset = 1'b1;
  logic ls = 0, ld = 0, sz = 0, rfen = 0;
  logic [31:0] addr = 0, alu = 0, sd = 0;
  logic [3:0] rd = 0;
  logic stall, wb_en;
  logic [3:0] wb_rd;
  logic [31:0] wb_data;
  logic ls4 = 0, ld4 = 0, sz4 = 0, rfen4 = 0;
  logic [31:0] addr4 = 0, alu4 = 0, sd4 = 0;
  logic [3:0] rd4 = 0;
  logic stall4, wb_en4;
  logic [3:0] wb_rd4;
  logic [31:0] wb_data4;
  int checks = 0, failures = 0;
  logic [7:0] ref_mem [256];
  typedef struct {logic en; logic [3:0] rd; logic [31:0] data;} wb_t;
  wb_t exp_q[$];
  bit active = 0;

  always #5 Clk = ~Clk;

  mem_stage #(.ADDR_WIDTH(8), .ACCESS_LATENCY(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .MEM_load_store_instr(ls), .MEM_load_instr(ld), .MEM_size(sz),
    .MEM_RF_enable(rfen), .MEM_address(addr), .MEM_alu_result(alu), .MEM_store_data(sd),
    .MEM_rd(rd), .MEM_stall(stall), .WB_RF_enable(wb_en), .WB_rd(wb_rd), .WB_data(wb_data));

  mem_stage #(.ADDR_WIDTH(8), .ACCESS_LATENCY(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .MEM_load_store_instr(ls4), .MEM_load_instr(ld4), .MEM_size(sz4),
    .MEM_RF_enable(rfen4), .MEM_address(addr4), .MEM_alu_result(alu4), .MEM_store_data(sd4),
    .MEM_rd(rd4), .MEM_stall(stall4), .WB_RF_enable(wb_en4), .WB_rd(wb_rd4), .WB_data(wb_data4));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [7:0] a, input bit word);
    return word ? {ref_mem[a], ref_mem[8'(a + 1)], ref_mem[8'(a + 2)], ref_mem[8'(a + 3)]}
                : {24'b0, ref_mem[a]};
  endfunction

  task automatic ref_write(input logic [7:0] a, input bit word, input logic [31:0] d);
    if (word) for (int k = 0; k < 4; k++) ref_mem[8'(a + k)] = d[31 - 8*k -: 8];
    else ref_mem[a] = d[7:0];
  endtask

  // present one instruction at a negedge, hold it through the stall, return at the negedge after commit
  task automatic do_op(input bit m, input bit l, input bit w, input bit en,
                       input logic [31:0] ad, input logic [31:0] al, input logic [31:0] s,
                       input logic [3:0] r);
    wb_t e;
    int n;
    ls = m; ld = l; sz = w; rfen = en; addr = ad; alu = al; sd = s; rd = r;
    e.en = en; e.rd = r; e.data = al;
    if (m && l) e.data = ref_read(ad[7:0], w);
    if (m && !l) ref_write(ad[7:0], w, s);
    exp_q.push_back(e);
    n = 0;
    #1;
    while (stall && n < 20) begin
      n++;
      @(posedge Clk); @(negedge Clk); #1;
    end
    check("stall_cycles", 64'(n), 64'(m ? LAT - 1 : 0));
    @(posedge Clk); @(negedge Clk);
  endtask

  // monitor: a non-stalled edge transfers one instruction into WB, a stalled edge a bubble
  initial begin
    logic xfer, bub;
    wb_t e;
    forever begin
      @(negedge Clk); #2;
      xfer = active && !stall;
      bub  = active && stall;
      @(posedge Clk); #1;
      if (xfer) begin
        if (exp_q.size() == 0) check("wb_unexpected", 64'(wb_en), 64'hF);
        else begin
          e = exp_q.pop_front();
          check("wb_rf_enable", 64'(wb_en), 64'(e.en));
          check("wb_rd", 64'(wb_rd), 64'(e.rd));
          check("wb_data", 64'(wb_data), 64'(e.data));
        end
      end
      if (bub) check("wb_bubble", {27'b0, wb_en, wb_rd, wb_data}, 64'd0);
    end
  end

  initial begin
    logic [7:0] b;
    int n;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      ref_mem[i] = b;
      dut.u_ram.mem[i] <= b;
    end
    for (int k = 0; k < 4; k++) dut4.u_ram.mem[8'h40 + k] <= 8'(8'hC0 + k);
    @(negedge Clk);
    ls = 1; #1;
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_wb", {27'b0, wb_en, wb_rd, wb_data}, 64'd0);
    ls = 0;
    @(negedge Clk);
    Reset = 0;
    active = 1;
    do_op(0, 0, SIZE_WORD, 1, 32'h0, 32'h12345678, 32'h0, 4'd3);
    active = 0;
    ls = 1; ld = 0; sz = SIZE_WORD; rfen = 0; addr = 32'h10; sd = 32'hDEADBEEF; rd = 0;
    @(posedge Clk); @(negedge Clk);
    Reset = 1; #1;
    check("abort_stall", 64'(stall), 64'd0);
    check("abort_wb", {27'b0, wb_en, wb_rd, wb_data}, 64'd0);
    @(posedge Clk); @(negedge Clk);
    ls = 0;
    Reset = 0;
    for (int k = 0; k < 4; k++) check("abort_ram", 64'(dut.u_ram.mem[8'h10 + k]), 64'(ref_mem[8'h10 + k]));
    active = 1;
    do_op(1, 0, SIZE_WORD, 0, 32'h20, 32'h0, 32'hAABBCCDD, 4'd0);
    check("ram_20", 64'(dut.u_ram.mem[8'h20]), 64'hAA);
    check("ram_23", 64'(dut.u_ram.mem[8'h23]), 64'hDD);
    do_op(1, 1, SIZE_WORD, 1, 32'h20, 32'h0, 32'h0, 4'd5);
    do_op(1, 0, SIZE_BYTE, 0, 32'h21, 32'h0, 32'h123456F0, 4'd0);
    check("ram_20_kept", 64'(dut.u_ram.mem[8'h20]), 64'hAA);
    check("ram_21_byte", 64'(dut.u_ram.mem[8'h21]), 64'hF0);
    check("ram_22_kept", 64'(dut.u_ram.mem[8'h22]), 64'hCC);
    do_op(1, 1, SIZE_BYTE, 1, 32'hFFFF_FF21, 32'h0, 32'h0, 4'd6);
    do_op(1, 0, SIZE_WORD, 1, 32'hFE, 32'h55, 32'h01020304, 4'd2);
    check("ram_fe", 64'(dut.u_ram.mem[8'hFE]), 64'h01);
    check("ram_ff", 64'(dut.u_ram.mem[8'hFF]), 64'h02);
    check("ram_00", 64'(dut.u_ram.mem[8'h00]), 64'h03);
    check("ram_01", 64'(dut.u_ram.mem[8'h01]), 64'h04);
    do_op(1, 1, SIZE_WORD, 1, 32'hFE, 32'h0, 32'h0, 4'd9);
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(1, 0) == 1) a[7:0] = 8'(8'hFC + $urandom_range(5, 0));
      do_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), a, $urandom, $urandom, 4'($urandom));
    end
    active = 0;
    ls = 0;
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    ls4 = 1; ld4 = 1; sz4 = SIZE_WORD; rfen4 = 1; rd4 = 4'd7; addr4 = 32'h40;
    n = 0;
    #1;
    while (stall4 && n < 10) begin
      n++;
      @(posedge Clk); #1;
      check("lat4_bubble_en", 64'(wb_en4), 64'd0);
      @(negedge Clk); #1;
    end
    check("lat4_stall_cycles", 64'(n), 64'd3);
    @(posedge Clk); #1;
    check("lat4_wb_en", 64'(wb_en4), 64'd1);
    check("lat4_wb_data", 64'(wb_data4), 64'hC0C1C2C3);
    ls4 = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the ARM pipeline, directly downstream of the EX/MEM register. Consumes the MEM-side control bits (load/store, size, RF enable) plus address, store data and destination register; performs byte/word accesses to a 256-byte big-endian data RAM with a configurable fixed access latency; stalls upstream while an access is in flight; and owns the MEM/WB pipeline register feeding write-back.

## Interface
- ADDR_WIDTH, 8, data RAM byte-address width (2^ADDR_WIDTH bytes)
- ACCESS_LATENCY, 2, cycles per load/store access, >= 1
- Clk  input  1  single clock, rising edge
- Reset  input  1  asynchronous, active-high
- MEM_load_store_instr  input  1  1 = memory access this cycle
- MEM_load_instr  input  1  1 = load, 0 = store (valid when MEM_load_store_instr = 1)
- MEM_size  input  1  1 = word, 0 = byte
- MEM_RF_enable  input  1  instruction writes the register file
- MEM_address  input  32  byte address (ALU result for memory ops)
- MEM_alu_result  input  32  result for non-load instructions
- MEM_store_data  input  32  store source (byte store uses [7:0])
- MEM_rd  input  4  destination register
- MEM_stall  output  1  hold upstream (PC, IF/ID, ID/EX, EX/MEM) this cycle
- WB_RF_enable  output  1  registered write enable to write-back
- WB_rd  output  4  registered destination
- WB_data  output  32  registered write-back value

## Operation
- FSM states IDLE, WAIT; 2-bit-min down-counter cnt.
- IDLE, no memory op: MEM_stall = 0; at the edge, WB register loads {MEM_RF_enable, MEM_rd, MEM_alu_result}.
- IDLE, memory op, ACCESS_LATENCY = 1: MEM_stall = 0; access commits at that edge.
- IDLE, memory op, ACCESS_LATENCY > 1: MEM_stall = 1; next state WAIT, cnt <= ACCESS_LATENCY-2; WB register loads bubble (WB_RF_enable = 0, WB_rd = 0, WB_data = 0).
- WAIT, cnt != 0: MEM_stall = 1; cnt decrements; WB bubble.
- WAIT, cnt == 0: MEM_stall = 0; access commits at the edge; next state IDLE.
- Commit: store writes RAM exactly once; load/other writes WB register {MEM_RF_enable, MEM_rd, result}.
- Upstream keeps all MEM_* inputs stable while MEM_stall = 1; block samples them at commit.
- Address: low ADDR_WIDTH bits of MEM_address; upper bits ignored.
- Word access big-endian: byte[a] = bits 31:24, byte[a+1] = 23:16, byte[a+2] = 15:8, byte[a+3] = 7:0; a+k wraps modulo 2^ADDR_WIDTH; no alignment requirement.
- Byte load zero-extends to 32 bits; byte store writes byte[a] only.
- Load result = RAM read value; WB_data takes it regardless of MEM_RF_enable.
- Store with MEM_RF_enable = 1 is treated as given: WB_RF_enable follows the input.
- RAM contents not reset; bench preloads via hierarchical access.

## Timing
- Reset (async, any time): state IDLE, cnt = 0, WB_RF_enable = 0, WB_rd = 0, WB_data = 0, MEM_stall = 0 while Reset high.
- Reset during WAIT aborts the access: no RAM write, no WB update.
- MEM_stall is combinational from state, cnt, MEM_load_store_instr; no dependence on address/data.
- Memory op latency: stall high ACCESS_LATENCY-1 cycles, WB outputs valid the cycle after commit edge.
- Non-memory op: WB outputs valid one cycle after presentation.
- Back-to-back memory ops: second op is presented the cycle after commit, starts in IDLE; no overlap.
- Load following a store to the same address observes the stored value.

## Structure
- Package mem_stage_pkg: state enum {IDLE, WAIT}; size encodings SIZE_BYTE = 0, SIZE_WORD = 1; default latency constant.
- Sub-module data_ram: 2^ADDR_WIDTH x 8 array, combinational big-endian read (byte/word, wraparound), synchronous write gated by we. FSM, counter and MEM/WB register live in mem_stage.

## Test plan
- Reset mid-WAIT during store of 0xDEADBEEF to 0x10 -> RAM[0x10..0x13] unchanged, WB outputs 0, MEM_stall 0.
- Non-memory op, rd = 3, alu_result = 0x12345678, RF_enable = 1 -> next cycle WB_rd = 3, WB_data = 0x12345678, MEM_stall never high.
- Word store 0xAABBCCDD to 0x20 then word load rd = 5 from 0x20 -> each stalls 1 cycle (latency 2); RAM[0x20] = 0xAA, RAM[0x23] = 0xDD; WB_data = 0xAABBCCDD.
- Byte store 0x1234_56F0 to 0x21, byte load 0x21 -> WB_data = 0x000000F0; RAM[0x20], RAM[0x22] unchanged.
- Word store 0x01020304 to 0xFE -> RAM[0xFE] = 0x01, RAM[0xFF] = 0x02, RAM[0x00] = 0x03, RAM[0x01] = 0x04; word load 0xFE returns 0x01020304.
- ACCESS_LATENCY = 4, load -> MEM_stall high exactly 3 cycles, WB_RF_enable 0 during them, 1 after commit.
